// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-lite pipeline: memory-stage FSM states,
// data-memory base address and the execute-stage command encodings.
package arm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   // Byte address of data-memory word 0
   localparam int unsigned ADDR_BASE_DEF = 1024;

   // Execute-stage commands (several instructions share an ALU operation)
   localparam logic [3:0] EXE_MOV         = 4'b0001;
   localparam logic [3:0] EXE_MVN         = 4'b1001;
   localparam logic [3:0] EXE_ADD         = 4'b0010;
   localparam logic [3:0] EXE_ADC         = 4'b0011;
   localparam logic [3:0] EXE_SUB         = 4'b0100;
   localparam logic [3:0] EXE_SBC         = 4'b0101;
   localparam logic [3:0] EXE_AND         = 4'b0110;
   localparam logic [3:0] EXE_ORR         = 4'b0111;
   localparam logic [3:0] EXE_EOR         = 4'b1000;
   localparam logic [3:0] EXE_CMP         = 4'b0100;
   localparam logic [3:0] EXE_TST         = 4'b0110;
   localparam logic [3:0] EXE_ADD_LDR_STR = 4'b0010;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/ready handshake between the memory-stage controller and the data cache.
interface mem_access_ctrl_if #(
   parameter int unsigned WORD_ADDR_W = 16
);
   logic                   cache_req;
   logic                   cache_we;
   logic [WORD_ADDR_W-1:0] cache_addr;
   logic [31:0]            cache_wdata;
   logic                   cache_ready;
   logic [31:0]            cache_rdata;

   modport master (
      output cache_req, cache_we, cache_addr, cache_wdata,
      input  cache_ready, cache_rdata
   );

   modport slave (
      input  cache_req, cache_we, cache_addr, cache_wdata,
      output cache_ready, cache_rdata
   );
endinterface

// File: rtl/mem_access_ctrl_addr_map.sv
// Byte-address to cache word-address mapping with fault detection.
// Shared with the SRAM backing controller.
module mem_addr_map
   import arm_pkg::*;
#(
   parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
   parameter int unsigned WORD_ADDR_W = 16
) (
   input  logic [31:0]            byte_addr_i,
   output logic [WORD_ADDR_W-1:0] word_addr_o,
   output logic                   fault_o
);

   localparam logic [31:0] BASE = 32'(ADDR_BASE);

   logic [31:0] rebased;
   logic [31:0] word_full;

   // Rebase, drop the byte offset, flag below-base / misaligned / out-of-range
   always_comb begin
      rebased     = byte_addr_i - BASE;
      word_full   = rebased >> 2;
      word_addr_o = word_full[WORD_ADDR_W-1:0];
      fault_o     = (byte_addr_i < BASE)
                 || (byte_addr_i[1:0] != 2'b00)
                 || ((word_full >> WORD_ADDR_W) != 32'd0);
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: freezes the pipeline while an LDR/STR
// runs a request/ready handshake with the data cache.
module mem_access_ctrl
   import arm_pkg::*;
#(
   parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
   parameter int unsigned WORD_ADDR_W = 16,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_r_en,
   input  logic               mem_w_en,
   input  logic [31:0]        alu_result,
   input  logic [31:0]        st_val,
   mem_access_ctrl_if.master  cache,
   output logic               freeze,
   output logic [31:0]        ld_data,
   output logic               err
);

   // Counter value seen during the last BUSY cycle before abort
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   mem_state_t             state_q, state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   req_q, req_d;
   logic                   we_q, we_d;
   logic [WORD_ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [31:0]            ld_q, ld_d;
   logic                   err_q, err_d;

   logic                   acc_en;
   logic                   timeout_hit;
   logic [WORD_ADDR_W-1:0] map_addr;
   logic                   map_fault;

   assign acc_en      = mem_r_en | mem_w_en;
   assign timeout_hit = (cnt_q == CNT_LAST);

   mem_addr_map #(
      .ADDR_BASE   (ADDR_BASE),
      .WORD_ADDR_W (WORD_ADDR_W)
   ) u_addr_map (
      .byte_addr_i (alu_result),
      .word_addr_o (map_addr),
      .fault_o     (map_fault)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state: faults skip BUSY; ready wins over a coincident timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (acc_en) state_d = map_fault ? DONE : BUSY;
         BUSY:    if (cache.cache_ready || timeout_hit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: combinational freeze plus next values of the registered bus/result
   always_comb begin
      freeze  = 1'b0;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ld_d    = ld_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (acc_en) begin
               freeze = 1'b1;
               if (map_fault) begin
                  err_d = 1'b1;
                  ld_d  = 32'd0;
               end else begin
                  req_d   = 1'b1;
                  we_d    = mem_w_en;
                  addr_d  = map_addr;
                  wdata_d = st_val;
               end
            end
         end
         BUSY: begin
            freeze = 1'b1;
            cnt_d  = cnt_q + 8'd1;
            if (cache.cache_ready) begin
               req_d = 1'b0;
               if (!we_q) ld_d = cache.cache_rdata;
            end else if (timeout_hit) begin
               req_d = 1'b0;
               err_d = 1'b1;
               ld_d  = 32'd0;
            end
         end
         DONE: begin
            cnt_d = 8'd0;
         end
         default: begin
            cnt_d = 8'd0;
         end
      endcase
      if (rst) freeze = 1'b0;
   end

   // Registered bus, load data, sticky error and timeout counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= 8'd0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         ld_q    <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ld_q    <= ld_d;
         err_q   <= err_d;
      end
   end

   assign cache.cache_req   = req_q;
   assign cache.cache_we    = we_q;
   assign cache.cache_addr  = addr_q;
   assign cache.cache_wdata = wdata_q;
   assign ld_data           = ld_q;
   assign err               = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a short timeout (TIMEOUT=4).
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_r_en, mem_w_en;
   logic [31:0] alu_result, st_val;
   logic        freeze, err;
   logic [31:0] ld_data;
   int          vecs = 0;
   int          miss = 0;

   mem_access_ctrl_if #(.WORD_ADDR_W(16)) cif ();

   mem_access_ctrl #(
      .ADDR_BASE   (1024),
      .WORD_ADDR_W (16),
      .TIMEOUT     (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_r_en   (mem_r_en),
      .mem_w_en   (mem_w_en),
      .alu_result (alu_result),
      .st_val     (st_val),
      .cache      (cif),
      .freeze     (freeze),
      .ld_data    (ld_data),
      .err        (err)
   );

   always #5 clk = ~clk;

   // One cycle of stimulus: drive on the falling edge, settle, then the caller checks
   task automatic drive(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] s, input logic rdy, input logic [31:0] rd);
      @(negedge clk);
      mem_r_en        = r;
      mem_w_en        = w;
      alu_result      = a;
      st_val          = s;
      cif.cache_ready = rdy;
      cif.cache_rdata = rd;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_r_en = 1'b1; mem_w_en = 1'b0; alu_result = 32'd1028;
      st_val = 32'h0; cif.cache_ready = 1'b0; cif.cache_rdata = 32'h0;
      #1;
      vecs++; if (freeze !== 1'b0) begin miss++; $display("FAIL rst_freeze got=%0h exp=0", freeze); end
      vecs++; if (cif.cache_req !== 1'b0) begin miss++; $display("FAIL rst_req got=%0h exp=0", cif.cache_req); end
      vecs++; if (cif.cache_we !== 1'b0) begin miss++; $display("FAIL rst_we got=%0h exp=0", cif.cache_we); end
      vecs++; if (cif.cache_addr !== 16'd0) begin miss++; $display("FAIL rst_addr got=%0h exp=0", cif.cache_addr); end
      vecs++; if (cif.cache_wdata !== 32'd0) begin miss++; $display("FAIL rst_wdata got=%0h exp=0", cif.cache_wdata); end
      vecs++; if (ld_data !== 32'd0) begin miss++; $display("FAIL rst_ld got=%0h exp=0", ld_data); end
      vecs++; if (err !== 1'b0) begin miss++; $display("FAIL rst_err got=%0h exp=0", err); end
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      rst = 1'b0;
      #1;
      vecs++; if (freeze !== 1'b0) begin miss++; $display("FAIL idle_freeze got=%0h exp=0", freeze); end
   endtask

   task automatic test_load_hit();
      drive(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, 32'd0);
      vecs++; if (freeze !== 1'b1) begin miss++; $display("FAIL ld_idle_freeze got=%0h exp=1", freeze); end
      vecs++; if (cif.cache_req !== 1'b0) begin miss++; $display("FAIL ld_idle_req got=%0h exp=0", cif.cache_req); end
      drive(1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, 32'hDEADBEEF);
      vecs++; if (freeze !== 1'b1) begin miss++; $display("FAIL ld_busy_freeze got=%0h exp=1", freeze); end
      vecs++; if (cif.cache_req !== 1'b1) begin miss++; $display("FAIL ld_busy_req got=%0h exp=1", cif.cache_req); end
      vecs++; if (cif.cache_addr !== 16'd1) begin miss++; $display("FAIL ld_addr got=%0h exp=1", cif.cache_addr); end
      vecs++; if (cif.cache_we !== 1'b0) begin miss++; $display("FAIL ld_we got=%0h exp=0", cif.cache_we); end
      drive(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, 32'd0);
      vecs++; if (freeze !== 1'b0) begin miss++; $display("FAIL ld_done_freeze got=%0h exp=0", freeze); end
      vecs++; if (cif.cache_req !== 1'b0) begin miss++; $display("FAIL ld_done_req got=%0h exp=0", cif.cache_req); end
      vecs++; if (ld_data !== 32'hDEADBEEF) begin miss++; $display("FAIL ld_data got=%0h exp=deadbeef", ld_data); end
      vecs++; if (err !== 1'b0) begin miss++; $display("FAIL ld_err got=%0h exp=0", err); end
   endtask

   task automatic test_store_miss();
      drive(1'b0, 1'b1, 32'd1036, 32'h12345678, 1'b0, 32'd0);
      vecs++; if (freeze !== 1'b1) begin miss++; $display("FAIL st_idle_freeze got=%0h exp=1", freeze); end
      for (int i = 0; i < 3; i++) begin
         // st_val changes under the frozen stage; the bus must hold the latched value
         drive(1'b0, 1'b1, 32'd1036, 32'h0BADF00D, (i == 2), 32'h55555555);
         vecs++; if (freeze !== 1'b1) begin miss++; $display("FAIL st_busy_freeze[%0d] got=%0h exp=1", i, freeze); end
         vecs++; if (cif.cache_req !== 1'b1) begin miss++; $display("FAIL st_req[%0d] got=%0h exp=1", i, cif.cache_req); end
         vecs++; if (cif.cache_we !== 1'b1) begin miss++; $display("FAIL st_we[%0d] got=%0h exp=1", i, cif.cache_we); end
         vecs++; if (cif.cache_addr !== 16'd3) begin miss++; $display("FAIL st_addr[%0d] got=%0h exp=3", i, cif.cache_addr); end
         vecs++; if (cif.cache_wdata !== 32'h12345678) begin miss++; $display("FAIL st_wdata[%0d] got=%0h exp=12345678", i, cif.cache_wdata); end
      end
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      vecs++; if (freeze !== 1'b0) begin miss++; $display("FAIL st_done_freeze got=%0h exp=0", freeze); end
      vecs++; if (cif.cache_req !== 1'b0) begin miss++; $display("FAIL st_done_req got=%0h exp=0", cif.cache_req); end
      vecs++; if (ld_data !== 32'hDEADBEEF) begin miss++; $display("FAIL st_ld_kept got=%0h exp=deadbeef", ld_data); end
   endtask

   task automatic test_simultaneous();
      drive(1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         // ready lands on the fourth BUSY cycle, the same edge the counter times out
         drive(1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, (i == 3), 32'h99999999);
         vecs++; if (cif.cache_req !== 1'b1) begin miss++; $display("FAIL sim_req[%0d] got=%0h exp=1", i, cif.cache_req); end
      end
      vecs++; if (cif.cache_we !== 1'b1) begin miss++; $display("FAIL sim_we got=%0h exp=1", cif.cache_we); end
      vecs++; if (cif.cache_addr !== 16'd2) begin miss++; $display("FAIL sim_addr got=%0h exp=2", cif.cache_addr); end
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      vecs++; if (err !== 1'b0) begin miss++; $display("FAIL sim_err got=%0h exp=0", err); end
      vecs++; if (cif.cache_req !== 1'b0) begin miss++; $display("FAIL sim_done_req got=%0h exp=0", cif.cache_req); end
      vecs++; if (freeze !== 1'b0) begin miss++; $display("FAIL sim_done_freeze got=%0h exp=0", freeze); end
      vecs++; if (ld_data !== 32'hDEADBEEF) begin miss++; $display("FAIL sim_ld_kept got=%0h exp=deadbeef", ld_data); end
   endtask

   task automatic test_reset_mid_op();
      drive(1'b1, 1'b0, 32'd1044, 32'd0, 1'b0, 32'd0);
      drive(1'b1, 1'b0, 32'd1044, 32'd0, 1'b0, 32'd0);
      vecs++; if (cif.cache_req !== 1'b1) begin miss++; $display("FAIL rmid_req_before got=%0h exp=1", cif.cache_req); end
      rst = 1'b1;
      #1;
      vecs++; if (cif.cache_req !== 1'b0) begin miss++; $display("FAIL rmid_req got=%0h exp=0", cif.cache_req); end
      vecs++; if (freeze !== 1'b0) begin miss++; $display("FAIL rmid_freeze got=%0h exp=0", freeze); end
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      rst = 1'b0;
      #1;
      vecs++; if (freeze !== 1'b0) begin miss++; $display("FAIL rmid_idle_freeze got=%0h exp=0", freeze); end
      vecs++; if (ld_data !== 32'd0) begin miss++; $display("FAIL rmid_ld got=%0h exp=0", ld_data); end
      vecs++; if (cif.cache_addr !== 16'd0) begin miss++; $display("FAIL rmid_addr got=%0h exp=0", cif.cache_addr); end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b0, 32'd1048, 32'd0, 1'b0, 32'd0);
      vecs++; if (freeze !== 1'b1) begin miss++; $display("FAIL b2b_idle1_freeze got=%0h exp=1", freeze); end
      drive(1'b1, 1'b0, 32'd1048, 32'd0, 1'b1, 32'h11111111);
      vecs++; if (cif.cache_addr !== 16'd6) begin miss++; $display("FAIL b2b_addr1 got=%0h exp=6", cif.cache_addr); end
      drive(1'b1, 1'b0, 32'd1048, 32'd0, 1'b0, 32'd0);
      vecs++; if (freeze !== 1'b0) begin miss++; $display("FAIL b2b_done1_freeze got=%0h exp=0", freeze); end
      vecs++; if (cif.cache_req !== 1'b0) begin miss++; $display("FAIL b2b_done1_req got=%0h exp=0", cif.cache_req); end
      vecs++; if (ld_data !== 32'h11111111) begin miss++; $display("FAIL b2b_ld1 got=%0h exp=11111111", ld_data); end
      drive(1'b1, 1'b0, 32'd1052, 32'd0, 1'b0, 32'd0);
      vecs++; if (freeze !== 1'b1) begin miss++; $display("FAIL b2b_idle2_freeze got=%0h exp=1", freeze); end
      drive(1'b1, 1'b0, 32'd1052, 32'd0, 1'b1, 32'h22222222);
      vecs++; if (cif.cache_req !== 1'b1) begin miss++; $display("FAIL b2b_req2 got=%0h exp=1", cif.cache_req); end
      vecs++; if (cif.cache_addr !== 16'd7) begin miss++; $display("FAIL b2b_addr2 got=%0h exp=7", cif.cache_addr); end
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      vecs++; if (ld_data !== 32'h22222222) begin miss++; $display("FAIL b2b_ld2 got=%0h exp=22222222", ld_data); end
   endtask

   task automatic test_addr_fault();
      logic [31:0] bad [3];
      bad[0] = 32'd1030;    // misaligned
      bad[1] = 32'd1000;    // below base
      bad[2] = 32'd263168;  // word 65536, past 16-bit word space
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, bad[i], 32'd0, 1'b0, 32'd0);
         vecs++; if (freeze !== 1'b1) begin miss++; $display("FAIL flt_idle_freeze[%0d] got=%0h exp=1", i, freeze); end
         drive(1'b1, 1'b0, bad[i], 32'd0, 1'b1, 32'h77777777);
         vecs++; if (cif.cache_req !== 1'b0) begin miss++; $display("FAIL flt_req[%0d] got=%0h exp=0", i, cif.cache_req); end
         vecs++; if (freeze !== 1'b0) begin miss++; $display("FAIL flt_done_freeze[%0d] got=%0h exp=0", i, freeze); end
         vecs++; if (err !== 1'b1) begin miss++; $display("FAIL flt_err[%0d] got=%0h exp=1", i, err); end
         vecs++; if (ld_data !== 32'd0) begin miss++; $display("FAIL flt_ld[%0d] got=%0h exp=0", i, ld_data); end
      end
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic test_timeout();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #1;
      vecs++; if (err !== 1'b0) begin miss++; $display("FAIL to_err_cleared got=%0h exp=0", err); end
      drive(1'b1, 1'b0, 32'd1040, 32'd0, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 32'd1040, 32'd0, 1'b0, 32'd0);
         vecs++; if (cif.cache_req !== 1'b1) begin miss++; $display("FAIL to_req[%0d] got=%0h exp=1", i, cif.cache_req); end
         vecs++; if (freeze !== 1'b1) begin miss++; $display("FAIL to_freeze[%0d] got=%0h exp=1", i, freeze); end
      end
      // ready in DONE must be ignored
      drive(1'b1, 1'b0, 32'd1040, 32'd0, 1'b1, 32'hFFFFFFFF);
      vecs++; if (cif.cache_req !== 1'b0) begin miss++; $display("FAIL to_req_drop got=%0h exp=0", cif.cache_req); end
      vecs++; if (err !== 1'b1) begin miss++; $display("FAIL to_err got=%0h exp=1", err); end
      vecs++; if (freeze !== 1'b0) begin miss++; $display("FAIL to_done_freeze got=%0h exp=0", freeze); end
      vecs++; if (ld_data !== 32'd0) begin miss++; $display("FAIL to_ld got=%0h exp=0", ld_data); end
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF);
      vecs++; if (ld_data !== 32'd0) begin miss++; $display("FAIL to_ld_ignore got=%0h exp=0", ld_data); end
      vecs++; if (cif.cache_req !== 1'b0) begin miss++; $display("FAIL to_idle_req got=%0h exp=0", cif.cache_req); end
   endtask

   initial begin
      test_reset();
      test_load_hit();
      test_store_miss();
      test_simultaneous();
      test_reset_mid_op();
      test_back_to_back();
      test_addr_fault();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
